// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_unit
// Description : Program-counter sequencer for a 24-bit, 3-byte-instruction
//               core. After reset it spends one BOOT cycle at pc=0 and then
//               enters RUN. In RUN it selects the next pc from halt, jump,
//               relative branch or sequential (pc+3). Jump and branch targets
//               must be multiples of 3. A misaligned target sends the unit to
//               the terminal FAULT state. halt_req sends it to the terminal
//               HALT state. Only rst_n leaves HALT or FAULT.
// Ports       :
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   stall            in   hold pc, state, counter and flags this cycle
//   branch_taken     in   relative branch to pc+3+imm
//   jump             in   absolute jump to jump_target
//   jal              in   with jump: write the link address
//   halt_req         in   enter HALT
//   imm[23:0]        in   signed byte offset for branches
//   jump_target[23:0] in  absolute jump address
//   pc[23:0]         out  current instruction address
//   pc_plus3[23:0]   out  pc+3 mod 2^24 (combinational)
//   link_addr[23:0]  out  registered return address
//   link_we          out  one-cycle link write strobe
//   kercimi_lart     out  last taken branch was backward (imm[23]=1)
//   kercimi_poshte   out  last taken branch was forward  (imm[23]=0)
//   halted           out  state is HALT
//   fault            out  state is FAULT
//   instr_count[23:0] out saturating retired-instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jal,
    input  logic        halt_req,
    input  logic [23:0] imm,
    input  logic [23:0] jump_target,
    output logic [23:0] pc,
    output logic [23:0] pc_plus3,
    output logic [23:0] link_addr,
    output logic        link_we,
    output logic        kercimi_lart,
    output logic        kercimi_poshte,
    output logic        halted,
    output logic        fault,
    output logic [23:0] instr_count
);

    localparam logic [23:0] c_INSTR_BYTES = 24'd3;
    localparam logic [23:0] c_CNT_MAX     = 24'hFFFFFF;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] pc_q, pc_d;
    logic [23:0] link_addr_q, link_addr_d;
    logic        link_we_q, link_we_d;
    logic        lart_q, lart_d;
    logic        poshte_q, poshte_d;
    logic [23:0] cnt_q, cnt_d;

    logic [23:0] w_pc_plus3;
    logic [23:0] w_branch_target;
    logic [23:0] w_candidate;
    logic        w_cand_aligned;
    logic [23:0] w_cnt_next;

    // ------------------------------------------------------------------------
    // Divisibility by 3 without a divider. 4 is congruent to 1 mod 3, so
    // summing the 2-bit digits of a value keeps its residue. Three folding
    // rounds take 24 bits down to a 3-bit value in 0..5. That value is a
    // multiple of 3 only when it is 0 or 3.
    // ------------------------------------------------------------------------
    function automatic logic mod3_is_zero(input logic [23:0] v);
        logic [5:0] s1;
        logic [3:0] s2;
        logic [2:0] s3;
        s1 = 6'd0;
        for (int i = 0; i < 12; i++) begin
            s1 = s1 + {4'b0000, v[2*i +: 2]};
        end
        s2 = {2'b00, s1[1:0]} + {2'b00, s1[3:2]} + {2'b00, s1[5:4]};
        s3 = {1'b0, s2[1:0]} + {1'b0, s2[3:2]};
        return (s3 == 3'd0) || (s3 == 3'd3);
    endfunction

    assign w_pc_plus3      = pc_q + c_INSTR_BYTES;
    // The 24-bit add wraps naturally. Two's complement makes negative
    // offsets work without sign handling.
    assign w_branch_target = w_pc_plus3 + imm;
    // Jump has priority over branch, so the jump target is the candidate
    // whenever both are requested.
    assign w_candidate     = jump ? jump_target : w_branch_target;
    assign w_cand_aligned  = mod3_is_zero(w_candidate);
    assign w_cnt_next      = (cnt_q == c_CNT_MAX) ? cnt_q : (cnt_q + 24'd1);

    // ------------------------------------------------------------------------
    // Next-state / next-pc logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        link_addr_d = link_addr_q;
        link_we_d   = 1'b0;          // strobe lasts one cycle unless re-armed
        lart_d      = lart_q;
        poshte_d    = poshte_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_BOOT: begin
                // Inputs are ignored for the single boot cycle.
                pc_d    = 24'd0;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (!stall) begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (jump || branch_taken) begin
                        if (!w_cand_aligned) begin
                            // A misaligned target does not retire. pc, the
                            // counter, the link and the direction flags are
                            // left as they were.
                            state_d = ST_FAULT;
                        end else begin
                            pc_d  = w_candidate;
                            cnt_d = w_cnt_next;
                            if (jump) begin
                                if (jal) begin
                                    link_addr_d = w_pc_plus3;
                                    link_we_d   = 1'b1;
                                end
                            end else begin
                                lart_d   = imm[23];
                                poshte_d = ~imm[23];
                            end
                        end
                    end else begin
                        // A sequential step is never checked for alignment.
                        // The wrap past 2^24 is intentional.
                        pc_d  = w_pc_plus3;
                        cnt_d = w_cnt_next;
                    end
                end
            end

            ST_HALT,
            ST_FAULT: begin
                // Terminal states: everything holds until reset.
                state_d = state_q;
            end

            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= 24'd0;
            link_addr_q <= 24'd0;
            link_we_q   <= 1'b0;
            lart_q      <= 1'b0;
            poshte_q    <= 1'b0;
            cnt_q       <= 24'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            link_addr_q <= link_addr_d;
            link_we_q   <= link_we_d;
            lart_q      <= lart_d;
            poshte_q    <= poshte_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pc             = pc_q;
    assign pc_plus3       = w_pc_plus3;
    assign link_addr      = link_addr_q;
    assign link_we        = link_we_q;
    assign kercimi_lart   = lart_q;
    assign kercimi_poshte = poshte_q;
    assign instr_count    = cnt_q;
    assign halted         = (state_q == ST_HALT);
    assign fault          = (state_q == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_next_unit
// Description : Directed bench for pc_next_unit. Each step drives inputs on
//               the falling edge and pushes the hand-derived expected output
//               state onto a queue. One time unit after the next rising edge
//               it pops that entry and compares it against the DUT. Reset
//               checks push and pop immediately because reset is
//               asynchronous.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

    typedef struct {
        string       tag;
        logic [23:0] pc;
        logic [23:0] cnt;
        logic [23:0] laddr;
        logic        lwe;
        logic        lart;
        logic        posh;
        logic        hlt;
        logic        flt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic        jal;
    logic        halt_req;
    logic [23:0] imm;
    logic [23:0] jump_target;
    logic [23:0] d_pc;
    logic [23:0] d_pc_plus3;
    logic [23:0] d_link_addr;
    logic        d_link_we;
    logic        d_lart;
    logic        d_poshte;
    logic        d_halted;
    logic        d_fault;
    logic [23:0] d_cnt;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    pc_next_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .jal            (jal),
        .halt_req       (halt_req),
        .imm            (imm),
        .jump_target    (jump_target),
        .pc             (d_pc),
        .pc_plus3       (d_pc_plus3),
        .link_addr      (d_link_addr),
        .link_we        (d_link_we),
        .kercimi_lart   (d_lart),
        .kercimi_poshte (d_poshte),
        .halted         (d_halted),
        .fault          (d_fault),
        .instr_count    (d_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t E(string tag, logic [23:0] pc, logic [23:0] cnt,
                               logic [23:0] laddr, logic lwe, logic lart,
                               logic posh, logic hlt, logic flt);
        exp_t e;
        e.tag = tag; e.pc = pc; e.cnt = cnt; e.laddr = laddr; e.lwe = lwe;
        e.lart = lart; e.posh = posh; e.hlt = hlt; e.flt = flt;
        return e;
    endfunction

    task automatic chk(string tag, string fld, logic [23:0] obs, logic [23:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, "pc",       d_pc,        e.pc);
            chk(e.tag, "pc_plus3", d_pc_plus3,  e.pc + 24'd3);
            chk(e.tag, "count",    d_cnt,       e.cnt);
            chk(e.tag, "link",     d_link_addr, e.laddr);
            chk(e.tag, "link_we",  {23'd0, d_link_we}, {23'd0, e.lwe});
            chk(e.tag, "lart",     {23'd0, d_lart},    {23'd0, e.lart});
            chk(e.tag, "poshte",   {23'd0, d_poshte},  {23'd0, e.posh});
            chk(e.tag, "halted",   {23'd0, d_halted},  {23'd0, e.hlt});
            chk(e.tag, "fault",    {23'd0, d_fault},   {23'd0, e.flt});
        end
    endtask

    // One clocked step: drive inputs at the falling edge, push the expected
    // state, and compare one time unit after the rising edge.
    task automatic cyc(logic s, logic br, logic j, logic jl, logic h,
                       logic [23:0] im, logic [23:0] jt, exp_t e);
        @(negedge clk);
        stall = s; branch_taken = br; jump = j; jal = jl; halt_req = h;
        imm = im; jump_target = jt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    // Called one time unit after a rising edge. Asserts reset mid-cycle,
    // checks the immediate effect, then releases it before the falling edge
    // and checks the BOOT state.
    task automatic reset_pulse(string tag);
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jal = 1'b0;
        halt_req = 1'b0; imm = 24'd0; jump_target = 24'd0;
        #1 rst_n = 1'b0;
        #1;
        sb.push_back(E({tag, "_rst"}, 24'h0, 24'd0, 24'h0, 0, 0, 0, 0, 0));
        compare_head();
        rst_n = 1'b1;
        #1;
        sb.push_back(E({tag, "_boot"}, 24'h0, 24'd0, 24'h0, 0, 0, 0, 0, 0));
        compare_head();
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jal = 1'b0;
        halt_req = 1'b0; imm = 24'd0; jump_target = 24'd0;
        @(posedge clk);
        #1;

        // Reset release followed by free-running sequential fetch.
        reset_pulse("r1");
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("boot_edge", 24'h000000, 24'd0, 24'h0, 0,0,0,0,0));
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("seq1",      24'h000003, 24'd1, 24'h0, 0,0,0,0,0));
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("seq2",      24'h000006, 24'd2, 24'h0, 0,0,0,0,0));
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("seq3",      24'h000009, 24'd3, 24'h0, 0,0,0,0,0));
        // Backward branch: 0x00000C + (-12) = 0.
        cyc(0,1,0,0,0, 24'hFFFFF4, 24'h0, E("br_back", 24'h000000, 24'd4, 24'h0, 0,1,0,0,0));
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("seq4",      24'h000003, 24'd5, 24'h0, 0,1,0,0,0));
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("seq5",      24'h000006, 24'd6, 24'h0, 0,1,0,0,0));
        // Jump-and-link from 6: link = 9, one-cycle strobe.
        cyc(0,0,1,1,0, 24'h0, 24'h000030, E("jal",   24'h000030, 24'd7, 24'h000009, 1,1,0,0,0));
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("jal_end",   24'h000033, 24'd8, 24'h000009, 0,1,0,0,0));
        // Forward branch: 0x36 + 3 = 0x39.
        cyc(0,1,0,0,0, 24'h000003, 24'h0, E("br_fwd", 24'h000039, 24'd9, 24'h000009, 0,0,1,0,0));
        // Stall overrides a jump-and-link; releasing it executes the jump.
        cyc(1,0,1,1,0, 24'h0, 24'h000060, E("stall",   24'h000039, 24'd9,  24'h000009, 0,0,1,0,0));
        cyc(0,0,1,0,0, 24'h0, 24'h000060, E("unstall", 24'h000060, 24'd10, 24'h000009, 0,0,1,0,0));
        // jal without jump is a plain sequential step.
        cyc(0,0,0,1,0, 24'h0, 24'h0, E("jal_only",  24'h000063, 24'd11, 24'h000009, 0,0,1,0,0));
        // Jump beats branch; the backward imm must not touch the flags.
        cyc(0,1,1,0,0, 24'hFFFFF4, 24'h000090, E("prio", 24'h000090, 24'd12, 24'h000009, 0,0,1,0,0));
        // Wrap at the top of the address space.
        cyc(0,0,1,0,0, 24'h0, 24'hFFFFFC, E("j_top", 24'hFFFFFC, 24'd13, 24'h000009, 0,0,1,0,0));
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("seq_top",   24'hFFFFFF, 24'd14, 24'h000009, 0,0,1,0,0));
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("wrap",      24'h000002, 24'd15, 24'h000009, 0,0,1,0,0));
        // Halt beats jump; HALT is terminal.
        cyc(0,0,1,0,1, 24'h0, 24'h000030, E("halt",      24'h000002, 24'd15, 24'h000009, 0,0,1,1,0));
        cyc(0,1,1,1,0, 24'h000003, 24'h000030, E("halt_hold", 24'h000002, 24'd15, 24'h000009, 0,0,1,1,0));

        // Inputs ignored in BOOT, then a misaligned branch faults.
        reset_pulse("r2");
        cyc(0,0,1,1,1, 24'h0, 24'h000030, E("boot_ign", 24'h000000, 24'd0, 24'h0, 0,0,0,0,0));
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("r2_seq",    24'h000003, 24'd1, 24'h0, 0,0,0,0,0));
        cyc(0,1,0,0,0, 24'h000001, 24'h0, E("misalign", 24'h000003, 24'd1, 24'h0, 0,0,0,0,1));
        cyc(0,0,1,1,0, 24'h0, 24'h000030, E("fault_hold", 24'h000003, 24'd1, 24'h0, 0,0,0,0,1));

        // Misaligned jump-and-link: no link write.
        reset_pulse("r3");
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("r3_boot",   24'h000000, 24'd0, 24'h0, 0,0,0,0,0));
        cyc(0,0,1,1,0, 24'h0, 24'h000031, E("jal_mis", 24'h000000, 24'd0, 24'h0, 0,0,0,0,1));

        // Reset during a link strobe cancels it at once.
        reset_pulse("r4");
        cyc(0,0,0,0,0, 24'h0, 24'h0, E("r4_boot",   24'h000000, 24'd0, 24'h0, 0,0,0,0,0));
        cyc(0,0,1,1,0, 24'h0, 24'h000030, E("jal2",  24'h000030, 24'd1, 24'h000003, 1,0,0,0,0));
        reset_pulse("r5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
